team_06_i2s_tx: RTL and testbench

TEAM_06_I2S_TX -- requirements
Module: team_06_i2s_tx

---
 rtl/team_06_i2s_pkg.sv | 13 +
 rtl/team_06_i2s_bclk_gen.sv | 34 +++
 rtl/team_06_i2s_tx.sv | 77 +++++++
 tb/tb_team_06_i2s_tx.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/team_06_i2s_pkg.sv
// Shared constants and helpers for the 8-bit mono I2S transmitter.
package team_06_i2s_pkg;
    localparam int SAMPLE_W     = 8;
    localparam int SLOTS        = 16;
    localparam int BCLK_DIV_DEF = 4;

    // Slot s carries sample bit (16-s) mod 8, so slot 1 is the MSB and slot 0 the LSB.
    function automatic logic [2:0] sd_index(input logic [3:0] slot);
        logic [3:0] t;
        t = 4'(SLOTS) - slot;
        return t[2:0];
    endfunction
endpackage

// File: rtl/team_06_i2s_bclk_gen.sv
// Bit-clock divider: registered 50% duty bclk plus a strobe in the clk where bclk falls.
module team_06_i2s_bclk_gen
    import team_06_i2s_pkg::*;
#(
    parameter int BCLK_DIV = BCLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bclk,
    output logic fall_tick
);
    logic [7:0] cnt;
    logic       term;

    assign term      = (cnt == 8'(BCLK_DIV - 1));
    // High during the clk whose closing edge drives bclk 1->0.
    assign fall_tick = en && term && bclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            bclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            bclk <= 1'b0;
        end else if (term) begin
            cnt  <= '0;
            bclk <= ~bclk;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end
endmodule

// File: rtl/team_06_i2s_tx.sv
// Mono 8-bit I2S serializer with a one-entry holding buffer and per-frame shadow register.
module team_06_i2s_tx
    import team_06_i2s_pkg::*;
#(
    parameter int BCLK_DIV = BCLK_DIV_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                i2s_bclk,
    output logic                i2s_ws,
    output logic                i2s_sd,
    output logic                underrun
);
    logic                fall_tick;
    logic                buf_full;
    logic [SAMPLE_W-1:0] buf_data;
    logic [SAMPLE_W-1:0] shadow;
    logic [SAMPLE_W-1:0] shadow_nxt;
    logic [3:0]          slot;
    logic [3:0]          slot_nxt;
    logic                load;
    logic                accept;

    team_06_i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .bclk      (i2s_bclk),
        .fall_tick (fall_tick)
    );

    assign sample_ready = ~buf_full;

    always_comb begin
        slot_nxt   = slot + 4'd1;
        load       = fall_tick && (slot_nxt == 4'd1);
        accept     = sample_valid && !buf_full;
        shadow_nxt = shadow;
        // An empty buffer at frame start sends silence; a same-clk accept still lands in the buffer.
        if (load)
            shadow_nxt = buf_full ? buf_data : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_full <= 1'b0;
            buf_data <= '0;
            shadow   <= '0;
            slot     <= '0;
            i2s_ws   <= 1'b0;
            i2s_sd   <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (accept) begin
                buf_full <= 1'b1;
                buf_data <= sample_in;
            end else if (load) begin
                buf_full <= 1'b0;
            end
            shadow   <= shadow_nxt;
            underrun <= load && !buf_full;
            if (!en) begin
                slot   <= '0;
                i2s_ws <= 1'b0;
                i2s_sd <= 1'b0;
            end else if (fall_tick) begin
                slot   <= slot_nxt;
                i2s_ws <= slot_nxt[3];
                i2s_sd <= shadow_nxt[sd_index(slot_nxt)];
            end
        end
    end
endmodule

// File: tb/tb_team_06_i2s_tx.sv
// Randomized bench for team_06_i2s_tx against a time-based frame model (BCLK_DIV=2).
module tb_team_06_i2s_tx;
    localparam int DIV    = 2;
    localparam int HALF   = DIV;
    localparam int SLOTCK = 2 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    logic       i2s_bclk, i2s_ws, i2s_sd, underrun;

    int checks = 0;
    int failures = 0;

    team_06_i2s_tx #(.BCLK_DIV(DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .i2s_bclk     (i2s_bclk),
        .i2s_ws       (i2s_ws),
        .i2s_sd       (i2s_sd),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    // Model state: k = enabled posedges since en rose; the rest derives from time.
    int         k;
    logic       m_full;
    logic [7:0] m_buf;
    logic [7:0] m_shadow;
    logic       m_under;
    logic [7:0] src_q[$];
    logic       p_ws, p_sd, p_bclk;
    int         under_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cur_slot();
        return (k / SLOTCK) % 16;
    endfunction

    task automatic model_reset();
        k = 0; m_full = 0; m_buf = 0; m_shadow = 0; m_under = 0;
        p_ws = 0; p_sd = 0; p_bclk = 0;
    endtask

    task automatic compare_outputs();
        int s;
        logic e_sd;
        s = cur_slot();
        e_sd = (k < SLOTCK) ? 1'b0 : m_shadow[(16 - s) % 8];
        chk("bclk", i2s_bclk, ((k / HALF) % 2 == 1));
        chk("ws", i2s_ws, (k >= SLOTCK) && (s >= 8));
        chk("sd", i2s_sd, e_sd);
        chk("underrun", underrun, m_under);
        chk("ready", sample_ready, !m_full);
    endtask

    // One clk: inputs driven at negedge, model stepped at posedge, outputs checked #1 later.
    task automatic cycle(input logic en_v);
        logic acc, fall, ld, full_pre, en_was;
        int s;
        en = en_v;
        sample_valid = (src_q.size() != 0);
        sample_in = (src_q.size() != 0) ? src_q[0] : 8'h00;
        @(posedge clk);
        full_pre = m_full;
        acc = sample_valid && !full_pre;
        m_under = 0;
        en_was = en_v;
        if (en_v) begin
            k++;
            s = cur_slot();
            fall = (k % SLOTCK == 0);
            ld = fall && (s == 1);
            if (ld) begin
                m_shadow = full_pre ? m_buf : 8'h00;
                m_under = !full_pre;
                if (full_pre) m_full = 0;
            end
        end else begin
            k = 0;
        end
        if (acc) begin
            m_full = 1;
            m_buf = sample_in;
            void'(src_q.pop_front());
        end
        #1;
        compare_outputs();
        if (en_was)
            chk("edge_align", ((i2s_ws != p_ws) || (i2s_sd != p_sd)) && !(p_bclk && !i2s_bclk), 0);
        if (underrun) under_cnt++;
        p_ws = i2s_ws; p_sd = i2s_sd; p_bclk = i2s_bclk;
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before the next posedge.
    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_bclk", i2s_bclk, 0);
        chk("rst_ws", i2s_ws, 0);
        chk("rst_sd", i2s_sd, 0);
        chk("rst_under", underrun, 0);
        chk("rst_ready", sample_ready, 1);
        src_q.delete();
        model_reset();
        sample_valid = 0;
        en = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        rst = 1'b0; en = 0; sample_valid = 0; sample_in = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // A5 pushed before the first falling edge, two full frames.
        src_q.push_back(8'hA5);
        for (int i = 0; i < 132; i++) cycle(1);

        // No samples: silent frames, one underrun per 64 clks.
        do_reset();
        under_cnt = 0;
        for (int i = 0; i < 128; i++) cycle(1);
        chk("under_per_128", under_cnt, 2);

        // Held valid stream 01,02,03 sent in consecutive frames.
        do_reset();
        src_q.push_back(8'h01); src_q.push_back(8'h02); src_q.push_back(8'h03);
        cycle(1);
        chk("first_accept_ready", sample_ready, 0);
        for (int i = 0; i < 260; i++) cycle(1);

        // Reset at slot 5 of an FF frame, then silence until a loaded frame.
        do_reset();
        src_q.push_back(8'hFF);
        guard = 0;
        while (!(cur_slot() == 5 && k >= SLOTCK) && guard < 200) begin cycle(1); guard++; end
        chk("reach_slot5", guard < 200, 1);
        do_reset();
        for (int i = 0; i < 80; i++) cycle(1);

        // Drop en at slot 10, push while idle, re-enable.
        do_reset();
        src_q.push_back(8'h3C);
        guard = 0;
        while (cur_slot() != 10 && guard < 200) begin cycle(1); guard++; end
        chk("reach_slot10", guard < 200, 1);
        cycle(0);
        chk("idle_bclk", i2s_bclk, 0);
        src_q.push_back(8'hC3);
        for (int i = 0; i < 6; i++) cycle(0);
        chk("idle_accept", sample_ready, 0);
        for (int i = 0; i < 80; i++) cycle(1);

        // Randomized traffic with occasional en drops and resets.
        do_reset();
        begin
            logic en_r = 1;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 199) == 0) en_r = ~en_r;
                if (src_q.size() == 0 && $urandom_range(0, 39) == 0)
                    src_q.push_back(8'($urandom));
                if ($urandom_range(0, 999) == 0) do_reset();
                else cycle(en_r);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
